// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for a two-road traffic light: tracks each road's phase and dwell,
// latches the first (lowest-coded) violation as a sticky fault, counts RED->GREEN entries.

module tlm_road_tracker #(
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_MIN = 2,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_r,
  input  logic             i_y,
  input  logic             i_g,
  output logic [1:0]       o_phase,
  output logic             o_dec_valid,
  output logic             o_dec_red,
  output logic             o_invalid,
  output logic             o_illegal,
  output logic             o_yel_short,
  output logic             o_grn_short,
  output logic [CNT_W-1:0] o_green_cnt
);
  localparam int DMAX = (GREEN_MIN > YELLOW_MIN) ? GREEN_MIN : YELLOW_MIN;
  localparam int DW   = $clog2(DMAX + 1);
  localparam logic [DW-1:0] L_DMAX = DW'(DMAX);
  localparam logic [DW-1:0] L_GMIN = DW'(GREEN_MIN);
  localparam logic [DW-1:0] L_YMIN = DW'(YELLOW_MIN);

  typedef enum logic [1:0] {
    PH_UNKNOWN = 2'd0,
    PH_RED     = 2'd1,
    PH_GREEN   = 2'd2,
    PH_YELLOW  = 2'd3
  } phase_t;

  phase_t           r_state, w_state_nxt, w_dec;
  logic [DW-1:0]    r_dwell, w_dwell_nxt;
  logic [CNT_W-1:0] r_green_cnt;
  logic             w_valid, w_cnt_inc;

  always_comb begin
    w_valid = 1'b1;
    w_dec   = PH_UNKNOWN;
    case ({i_r, i_y, i_g})
      3'b100:  w_dec = PH_RED;
      3'b010:  w_dec = PH_YELLOW;
      3'b001:  w_dec = PH_GREEN;
      default: w_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;
    w_cnt_inc   = 1'b0;
    o_invalid   = 1'b0;
    o_illegal   = 1'b0;
    o_yel_short = 1'b0;
    o_grn_short = 1'b0;
    if (!w_valid) begin
      w_state_nxt = PH_UNKNOWN;
      w_dwell_nxt = '0;
      o_invalid   = 1'b1;
    end else if (r_state == PH_UNKNOWN) begin
      w_state_nxt = w_dec;
      w_dwell_nxt = DW'(1);
    end else if (w_dec == r_state) begin
      if (r_dwell != L_DMAX) w_dwell_nxt = r_dwell + 1'b1;
    end else begin
      // Any change loads the new phase; the dwell being left is judged only on legal steps.
      w_state_nxt = w_dec;
      w_dwell_nxt = DW'(1);
      case (r_state)
        PH_RED: begin
          if (w_dec == PH_GREEN) w_cnt_inc = 1'b1;
          else                   o_illegal = 1'b1;
        end
        PH_GREEN: begin
          if (w_dec == PH_YELLOW) o_grn_short = (r_dwell < L_GMIN);
          else                    o_illegal   = 1'b1;
        end
        PH_YELLOW: begin
          if (w_dec == PH_RED) o_yel_short = (r_dwell < L_YMIN);
          else                 o_illegal   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= PH_UNKNOWN;
      r_dwell     <= '0;
      r_green_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dwell <= w_dwell_nxt;
      if (w_cnt_inc) r_green_cnt <= r_green_cnt + 1'b1;
    end
  end

  assign o_phase     = r_state;
  assign o_dec_valid = w_valid;
  assign o_dec_red   = (w_dec == PH_RED);
  assign o_green_cnt = r_green_cnt;
endmodule

module traffic_light_monitor #(
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_MIN = 2,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ra,
  input  logic             i_ya,
  input  logic             i_ga,
  input  logic             i_rb,
  input  logic             i_yb,
  input  logic             i_gb,
  output logic             o_fault,
  output logic [3:0]       o_fault_code,
  output logic [1:0]       o_phase_a,
  output logic [1:0]       o_phase_b,
  output logic [CNT_W-1:0] o_green_cnt_a,
  output logic [CNT_W-1:0] o_green_cnt_b
);
  logic       w_a_vld, w_a_red, w_a_inv, w_a_ill, w_a_ysh, w_a_gsh;
  logic       w_b_vld, w_b_red, w_b_inv, w_b_ill, w_b_ysh, w_b_gsh;
  logic [3:0] w_code;
  logic       r_fault;
  logic [3:0] r_fault_code;

  tlm_road_tracker #(.GREEN_MIN(GREEN_MIN), .YELLOW_MIN(YELLOW_MIN), .CNT_W(CNT_W)) u_road_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_r(i_ra), .i_y(i_ya), .i_g(i_ga),
    .o_phase(o_phase_a), .o_dec_valid(w_a_vld), .o_dec_red(w_a_red),
    .o_invalid(w_a_inv), .o_illegal(w_a_ill), .o_yel_short(w_a_ysh),
    .o_grn_short(w_a_gsh), .o_green_cnt(o_green_cnt_a)
  );

  tlm_road_tracker #(.GREEN_MIN(GREEN_MIN), .YELLOW_MIN(YELLOW_MIN), .CNT_W(CNT_W)) u_road_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_r(i_rb), .i_y(i_yb), .i_g(i_gb),
    .o_phase(o_phase_b), .o_dec_valid(w_b_vld), .o_dec_red(w_b_red),
    .o_invalid(w_b_inv), .o_illegal(w_b_ill), .o_yel_short(w_b_ysh),
    .o_grn_short(w_b_gsh), .o_green_cnt(o_green_cnt_b)
  );

  // Lowest code wins when several violations coincide.
  always_comb begin
    w_code = 4'd0;
    if (w_a_inv)                                      w_code = 4'd1;
    else if (w_b_inv)                                 w_code = 4'd2;
    else if (w_a_vld && w_b_vld && !w_a_red && !w_b_red) w_code = 4'd3;
    else if (w_a_ill)                                 w_code = 4'd4;
    else if (w_b_ill)                                 w_code = 4'd5;
    else if (w_a_ysh)                                 w_code = 4'd6;
    else if (w_b_ysh)                                 w_code = 4'd7;
    else if (w_a_gsh)                                 w_code = 4'd8;
    else if (w_b_gsh)                                 w_code = 4'd9;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fault      <= 1'b0;
      r_fault_code <= 4'd0;
    end else if (!r_fault && (w_code != 4'd0)) begin
      r_fault      <= 1'b1;
      r_fault_code <= w_code;
    end
  end

  assign o_fault      = r_fault;
  assign o_fault_code = r_fault_code;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed vector table, corner sequences, and random
// lamp traffic checked against a trace-based reference model.

module tb_traffic_light_monitor;
  localparam int GMIN = 4;
  localparam int YMIN = 2;
  localparam int CW   = 8;
  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LX = 3'b110;

  logic          clk, rst, ra, ya, ga, rb, yb, gb;
  logic          fault;
  logic [3:0]    fault_code;
  logic [1:0]    phase_a, phase_b;
  logic [CW-1:0] cnt_a, cnt_b;

  traffic_light_monitor #(.GREEN_MIN(GMIN), .YELLOW_MIN(YMIN), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ra(ra), .i_ya(ya), .i_ga(ga), .i_rb(rb), .i_yb(yb), .i_gb(gb),
    .o_fault(fault), .o_fault_code(fault_code),
    .o_phase_a(phase_a), .o_phase_b(phase_b),
    .o_green_cnt_a(cnt_a), .o_green_cnt_b(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the decoded sample history since reset; phase is the last sample,
  // dwell is the length of the trailing run of identical samples.
  typedef struct { int d0; int d1; } smp_t;
  smp_t trace[$];
  int   m_cnt_a, m_cnt_b, m_code;
  bit   m_fault;

  function automatic int dec(input logic [2:0] l);
    case (l)
      3'b100:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int get_d(input int idx, input int road);
    return (road == 0) ? trace[idx].d0 : trace[idx].d1;
  endfunction

  function automatic int cur_phase(input int road);
    int d;
    if (trace.size() == 0) return 0;
    d = get_d(trace.size() - 1, road);
    return (d < 0) ? 0 : d;
  endfunction

  function automatic int run_len(input int road);
    int p = cur_phase(road);
    int n = 0;
    for (int i = trace.size() - 1; i >= 0; i--) begin
      if (get_d(i, road) == p) n++;
      else break;
    end
    return n;
  endfunction

  task automatic eval_road(input int road, input int d,
                           output bit inv, output bit ill, output bit ysh,
                           output bit gsh, output bit entry);
    int prev = cur_phase(road);
    int run  = run_len(road);
    inv = 0; ill = 0; ysh = 0; gsh = 0; entry = 0;
    if (d < 0) inv = 1;
    else if (prev != 0 && d != prev) begin
      if ((prev == 1 && d == 2) || (prev == 2 && d == 3) || (prev == 3 && d == 1)) begin
        gsh   = (prev == 2) && (run < GMIN);
        ysh   = (prev == 3) && (run < YMIN);
        entry = (prev == 1);
      end else ill = 1;
    end
  endtask

  task automatic model_update(input logic r, input logic [2:0] a, input logic [2:0] b);
    int da, db, code;
    bit ai, al, ay, ag, ae, bi, bl, by, bg, be;
    smp_t s;
    if (r) begin
      trace.delete();
      m_fault = 0; m_code = 0; m_cnt_a = 0; m_cnt_b = 0;
      return;
    end
    da = dec(a);
    db = dec(b);
    eval_road(0, da, ai, al, ay, ag, ae);
    eval_road(1, db, bi, bl, by, bg, be);
    code = 0;
    if (ai) code = 1;
    else if (bi) code = 2;
    else if (da != 1 && db != 1) code = 3;
    else if (al) code = 4;
    else if (bl) code = 5;
    else if (ay) code = 6;
    else if (by) code = 7;
    else if (ag) code = 8;
    else if (bg) code = 9;
    if (ae) m_cnt_a++;
    if (be) m_cnt_b++;
    s.d0 = da; s.d1 = db;
    trace.push_back(s);
    if (trace.size() > 64) void'(trace.pop_front());
    if (!m_fault && code != 0) begin
      m_fault = 1;
      m_code  = code;
    end
  endtask

  task automatic step(input logic r, input logic [2:0] a, input logic [2:0] b);
    rst = r;
    {ra, ya, ga} = a;
    {rb, yb, gb} = b;
    @(posedge clk);
    model_update(r, a, b);
    #1;
    check("model_fault",      fault,      m_fault);
    check("model_fault_code", fault_code, m_code);
    check("model_phase_a",    phase_a,    cur_phase(0));
    check("model_phase_b",    phase_b,    cur_phase(1));
    check("model_green_cnt_a", cnt_a,     m_cnt_a % (1 << CW));
    check("model_green_cnt_b", cnt_b,     m_cnt_b % (1 << CW));
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] a, b;
    logic       f;
    logic [3:0] c;
    logic [1:0] pa, pb;
    int         ca, cb;
  } vec_t;
  vec_t vt[$];

  task automatic add_v(input logic r, input logic [2:0] a, input logic [2:0] b, input int n,
                       input logic f, input logic [3:0] c, input logic [1:0] pa,
                       input logic [1:0] pb, input int ca, input int cb);
    vec_t v;
    v.rst = r; v.a = a; v.b = b; v.f = f; v.c = c;
    v.pa = pa; v.pb = pb; v.ca = ca; v.cb = cb;
    for (int i = 0; i < n; i++) vt.push_back(v);
  endtask

  logic [2:0] cur_a, cur_b;

  function automatic logic [2:0] next_lamp(input logic [2:0] cur);
    int k;
    case (cur)
      LR: return LG;
      LG: return LY;
      LY: return LR;
      default: begin
        k = $urandom_range(0, 2);
        return (k == 0) ? LR : ((k == 1) ? LG : LY);
      end
    endcase
  endfunction

  function automatic logic [2:0] rand_lamp(input logic [2:0] cur);
    int k = $urandom_range(0, 15);
    logic [2:0] v;
    if (k < 9) return cur;
    if (k < 14) return next_lamp(cur);
    v = 3'($urandom_range(0, 7));
    return v;
  endfunction

  initial begin
    rst = 1'b1; {ra, ya, ga} = LG; {rb, yb, gb} = LG;

    // Reset, two full legal alternations, then both green and later violations.
    add_v(1, LG,    LG, 1, 0, 0, 0, 0, 0, 0);
    add_v(1, 3'h7,  3'h0, 1, 0, 0, 0, 0, 0, 0);
    add_v(0, LR, LR, 1, 0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      add_v(0, LG, LR, 4, 0, 0, 2, 1, k + 1, k);
      add_v(0, LY, LR, 2, 0, 0, 3, 1, k + 1, k);
      add_v(0, LR, LR, 1, 0, 0, 1, 1, k + 1, k);
      add_v(0, LR, LG, 4, 0, 0, 1, 2, k + 1, k + 1);
      add_v(0, LR, LY, 2, 0, 0, 1, 3, k + 1, k + 1);
      add_v(0, LR, LR, 1, 0, 0, 1, 1, k + 1, k + 1);
    end
    add_v(0, LG, LG, 1, 1, 3, 2, 2, 3, 3);
    add_v(0, LR, LG, 1, 1, 3, 1, 2, 3, 3);
    add_v(0, LX, LG, 1, 1, 3, 0, 2, 3, 3);

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].a, vt[i].b);
      check($sformatf("vec%0d_fault", i),      fault,      vt[i].f);
      check($sformatf("vec%0d_fault_code", i), fault_code, vt[i].c);
      check($sformatf("vec%0d_phase_a", i),    phase_a,    vt[i].pa);
      check($sformatf("vec%0d_phase_b", i),    phase_b,    vt[i].pb);
      check($sformatf("vec%0d_green_cnt_a", i), cnt_a,     vt[i].ca);
      check($sformatf("vec%0d_green_cnt_b", i), cnt_b,     vt[i].cb);
    end

    // Green dropped straight to red on A.
    step(1, LR, LR);
    step(0, LR, LR);
    step(0, LG, LR);
    step(0, LR, LR);
    check("illegal_a_fault", fault, 1);
    check("illegal_a_code", fault_code, 4);

    // Reset mid-fault, then first sample loads RED without a check.
    step(1, LR, LR);
    check("rst_mid_fault", fault, 0);
    check("rst_mid_code", fault_code, 0);
    check("rst_mid_phase_a", phase_a, 0);
    step(0, LR, LR);
    check("post_rst_phase_a", phase_a, 1);
    check("post_rst_fault", fault, 0);

    // Yellow held one cycle on A.
    for (int i = 0; i < 4; i++) step(0, LG, LR);
    step(0, LY, LR);
    check("yel_ok_so_far", fault, 0);
    step(0, LR, LR);
    check("yel_short_code", fault_code, 6);

    // Green held one short of the minimum on B.
    step(1, LR, LR);
    step(0, LR, LR);
    for (int i = 0; i < GMIN - 1; i++) step(0, LR, LG);
    step(0, LR, LY);
    check("grn_short_code", fault_code, 9);

    // Invalid A encoding while B is green beats everything else.
    step(1, LR, LR);
    step(0, LR, LR);
    step(0, LR, LG);
    step(0, LX, LG);
    check("invalid_a_code", fault_code, 1);
    check("invalid_a_phase", phase_a, 0);

    // B green-entry counter wraps silently.
    step(1, LR, LR);
    step(0, LR, LR);
    for (int i = 0; i < 256; i++) begin
      step(0, LR, LG);
      if (i == 254) check("wrap_pre", cnt_b, 255);
      step(0, LR, LR);
    end
    check("wrap_post", cnt_b, 0);
    check("wrap_cnt_a", cnt_a, 0);

    // Random lamp traffic with occasional resets.
    cur_a = LR; cur_b = LR;
    step(1, LR, LR);
    for (int n = 0; n < 1500; n++) begin
      cur_a = rand_lamp(cur_a);
      cur_b = rand_lamp(cur_b);
      if (cur_a != LR && cur_b != LR && $urandom_range(0, 3) != 0) cur_b = LR;
      step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, cur_a, cur_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the lamp outputs of the two-road traffic light controller. It reads the six lamp signals (ra/ya/ga for road A, rb/yb/gb for road B) every clock. It tracks each road's light phase and dwell time, and flags the first safety or sequencing violation with a sticky fault and code. It sits beside the controller in the top level and in simulation benches as a run-time safety monitor; it drives nothing back into the controller.

## Interface
- GREEN_MIN, default 4: minimum clock cycles a road's green must be held before leaving green.
- YELLOW_MIN, default 2: minimum clock cycles a road's yellow must be held before leaving yellow.
- CNT_W, default 8: width of the per-road green-entry counters.
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- ra, ya, ga  input  1 each  road A red/yellow/green lamps.
- rb, yb, gb  input  1 each  road B red/yellow/green lamps.
- fault  output  1  sticky violation flag.
- fault_code  output  4  code of the first violation; 0 when no fault.
- phase_a, phase_b  output  2 each  tracked phase: 0 UNKNOWN, 1 RED, 2 GREEN, 3 YELLOW.
- green_cnt_a, green_cnt_b  output  CNT_W each  number of RED->GREEN entries; wraps modulo 2^CNT_W.

## Operation
- Decode per road, each cycle: exactly one lamp high gives RED, GREEN or YELLOW. Zero or more than one lamp high gives INVALID.
- Tracker FSM per road, with states UNKNOWN, RED, GREEN, YELLOW:
  - UNKNOWN + valid decode: load the decoded phase, set dwell=1, perform no transition check.
  - Same phase as held: dwell increments, saturating at max(GREEN_MIN, YELLOW_MIN).
  - Legal change (RED->GREEN, GREEN->YELLOW, YELLOW->RED): check the dwell of the phase being left, then load the new phase with dwell=1.
  - Illegal change (GREEN->RED, YELLOW->GREEN, RED->YELLOW): flag it and load the new phase anyway.
  - INVALID decode: flag it and go to UNKNOWN.
- Fault codes, per cycle:
  - 1: A lamp encoding invalid.
  - 2: B lamp encoding invalid.
  - 3: conflict, meaning neither road's decode is RED in the same cycle (both decodes must be valid).
  - 4/5: illegal transition on A/B.
  - 6/7: yellow left with dwell < YELLOW_MIN on A/B.
  - 8/9: green left with dwell < GREEN_MIN on A/B.
- When several violations occur in the same cycle, the lowest code is recorded.
- fault and fault_code are captured only while fault=0. Once fault=1 they hold until rst; later violations are ignored.
- Trackers, dwell counters and green counters keep running after a fault.
- green_cnt_x increments on each RED->GREEN transition only. A first load of GREEN from UNKNOWN does not count.

## Timing
- Reset (rst=1 at a rising edge) sets:
  - fault=0, fault_code=0.
  - phase_a=phase_b=0 (UNKNOWN).
  - dwell counters 0.
  - green_cnt_a=green_cnt_b=0.
- Reset takes priority over all checks on the same edge.
- Lamp inputs are sampled at rising edge N. The tracker update and any fault capture happen on that same edge N. So fault/fault_code are visible one cycle after the offending lamp pattern is driven, with no extra pipeline.
- Dwell counting: a phase held across k sampling edges has dwell=k when the next, differing sample arrives.
  - A green held exactly GREEN_MIN edges passes the green check.
  - A green held GREEN_MIN-1 edges fails.
- Reset mid-operation: all state returns to reset values at that edge. The first sample after rst deasserts is treated as UNKNOWN->phase with no check.
- Wrap: green_cnt 2^CNT_W-1 -> 0 on the next entry, with no flag.

## Test plan
- Reset check: hold rst=1 for 2 cycles with arbitrary lamps, then release -> fault=0, fault_code=0, phase_a=phase_b=0, green_cnt=0. The first sample after release shows phase_a=1 (RED) if ra=1.
- Legal sequence, with GREEN_MIN=4 and YELLOW_MIN=2, over two full alternations: A green 4 cycles, yellow 2, red while B runs green 4, yellow 2 -> fault stays 0, green_cnt_a=2, green_cnt_b=2.
- Both green: drive ga=1 and gb=1 for one cycle -> fault=1, fault_code=3 after that edge. The code still holds 3 after later violations.
- A goes GREEN->RED directly (ga then ra) -> fault_code=4. Separately, A yellow for 1 cycle with YELLOW_MIN=2 -> fault_code=6.
- Simultaneous violations: ra=ya=1 while B is green -> fault_code=1 (beats 3), phase_a=0.
- Reset mid-fault: with fault=1 and code 4, pulse rst=1 for one edge -> fault=0, code=0. A B green entry 255->0 with CNT_W=8 wraps silently.
